stopwatch_counter: RTL and testbench

Time-base and run-control block for the stopwatch. Divides `mclk` down to 0.01 s ticks and counts elapsed time as packed BCD minutes, seconds and hundredths. Decodes the start/stop and clear buttons into a `run` flag. Its `min`, `sec`, `mil` and `run` outputs connect directly to the time and run inputs of the lap-time/7-segment display stage.

---
 rtl/stopwatch_counter_pkg.sv | 28 ++
 rtl/stopwatch_counter_bcd2.sv | 28 ++
 rtl/stopwatch_counter.sv | 143 ++++++++++++++
 tb/tb_stopwatch_counter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared definitions for the stopwatch time base.
// State encodings, BCD wrap limits and default clocking.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } swState_t;

  localparam logic [7:0] BCD_LIM_99 = 8'h99;
  localparam logic [7:0] BCD_LIM_59 = 8'h59;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 100;

  function automatic logic [7:0] bcdNext(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    logic [7:0] r;
    r = {v[7:4], v[3:0] + 4'd1};
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    if (v == lim) r = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_counter_bcd2.sv
// Two-digit packed BCD counter with configurable wrap value.
// carry is combinational so a chain of these advances in one cycle.
module bcd2_counter
  import stopwatch_counter_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_LIM_99
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] val,
  output logic       carry
);

  assign carry = inc & (val == MAX);

  always_ff @(posedge mclk) begin
    if (reset) begin
      val <= 8'h00;
    end else if (clr) begin
      val <= 8'h00;
    end else if (inc) begin
      val <= bcdNext(val, MAX);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: button edge decode, run FSM,
// 0.01 s prescaler and a BCD min:sec.hundredths cascade.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       b1,
  input  logic       b3,
  output logic       run,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] mil,
  output logic       tick,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [2:0]    b1Sync;
  logic [2:0]    b3Sync;
  logic [1:0]    fillCnt;
  logic          b1Armed;
  logic          b3Armed;
  logic          b1Edge;
  logic          b3Edge;
  swState_t      state;
  swState_t      stateNext;
  logic          clrTime;
  logic [PW-1:0] pre;
  logic          tickInt;
  logic          milCarry;
  logic          secCarry;
  logic          minCarry;

  // A level held through reset must not count as a press:
  // an edge is only armed once a real low sample has been seen.
  always_ff @(posedge mclk) begin
    if (reset) begin
      b1Sync  <= 3'b000;
      b3Sync  <= 3'b000;
      fillCnt <= 2'd0;
      b1Armed <= 1'b0;
      b3Armed <= 1'b0;
    end else begin
      b1Sync  <= {b1Sync[1:0], b1};
      b3Sync  <= {b3Sync[1:0], b3};
      if (fillCnt != 2'd2) fillCnt <= fillCnt + 2'd1;
      b1Armed <= b1Armed | ((fillCnt == 2'd2) & ~b1Sync[1]);
      b3Armed <= b3Armed | ((fillCnt == 2'd2) & ~b3Sync[1]);
    end
  end

  assign b1Edge = b1Sync[1] & ~b1Sync[2] & b1Armed;
  assign b3Edge = b3Sync[1] & ~b3Sync[2] & b3Armed;

  always_ff @(posedge mclk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    clrTime   = 1'b0;
    unique case (state)
      IDLE: begin
        if (b1Edge) stateNext = RUN;
      end
      RUN: begin
        if (b1Edge) stateNext = PAUSE;
      end
      PAUSE: begin
        if (b3Edge) begin
          stateNext = IDLE;
          clrTime   = 1'b1;
        end else if (b1Edge) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign tickInt = (state == RUN) && (pre == PRE_LAST);

  // Held in PAUSE so a resumed period keeps its partial tick.
  always_ff @(posedge mclk) begin
    if (reset) begin
      pre <= '0;
    end else if (clrTime) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tickInt ? '0 : pre + PW'(1);
    end
  end

  bcd2_counter #(.MAX(BCD_LIM_99)) uMil (
    .mclk  (mclk),
    .reset (reset),
    .clr   (clrTime),
    .inc   (tickInt),
    .val   (mil),
    .carry (milCarry)
  );

  bcd2_counter #(.MAX(BCD_LIM_59)) uSec (
    .mclk  (mclk),
    .reset (reset),
    .clr   (clrTime),
    .inc   (milCarry),
    .val   (sec),
    .carry (secCarry)
  );

  bcd2_counter #(.MAX(BCD_LIM_99)) uMin (
    .mclk  (mclk),
    .reset (reset),
    .clr   (clrTime),
    .inc   (secCarry),
    .val   (min),
    .carry (minCarry)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      run  <= 1'b0;
      tick <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      run  <= (stateNext == RUN);
      tick <= tickInt;
      ovf  <= minCarry;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter against an
// elapsed-time reference model (DIV = 10).
module tb_stopwatch_counter;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = 10;
  localparam int FULL    = 600000;

  logic       mclk  = 1'b0;
  logic       reset = 1'b1;
  logic       b1    = 1'b0;
  logic       b3    = 1'b0;
  logic       run;
  logic [7:0] min;
  logic [7:0] sec;
  logic [7:0] mil;
  logic       tick;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  stopwatch_counter #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .mclk  (mclk),
    .reset (reset),
    .b1    (b1),
    .b3    (b3),
    .run   (run),
    .min   (min),
    .sec   (sec),
    .mil   (mil),
    .tick  (tick),
    .ovf   (ovf)
  );

  always #5 mclk = ~mclk;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mMode_t;

  mMode_t   mMode   = M_IDLE;
  int       mPhase  = 0;
  int       mCentis = 0;
  bit       mTick   = 1'b0;
  bit       mOvf    = 1'b0;
  bit [2:0] hVal    = 3'b0;
  bit [2:0] hReal   = 3'b0;
  bit [2:0] gVal    = 3'b0;
  bit [2:0] gReal   = 3'b0;
  int       preloadReq = -1;
  logic [7:0] pMin, pSec, pMil;

  // Reference: elapsed hundredths plus phase within the current period.
  always @(posedge mclk) begin : model
    mMode_t nMode;
    int nPhase, nCentis;
    bit nTick, nOvf, e1, e3;
    nMode   = mMode;
    nPhase  = mPhase;
    nCentis = mCentis;
    nTick   = 1'b0;
    nOvf    = 1'b0;
    e1 = hReal[1] && hReal[2] && hVal[1] && !hVal[2];
    e3 = gReal[1] && gReal[2] && gVal[1] && !gVal[2];
    if (preloadReq >= 0) nCentis = preloadReq;
    if (mMode == M_RUN) begin
      nPhase = mPhase + 1;
      if (nPhase == DIV) begin
        nPhase  = 0;
        nCentis = (nCentis + 1) % FULL;
        nTick   = 1'b1;
        nOvf    = (nCentis == 0);
      end
    end
    case (mMode)
      M_IDLE:  if (e1) nMode = M_RUN;
      M_RUN:   if (e1) nMode = M_PAUSE;
      default: begin
        if (e3) begin
          nMode = M_IDLE; nPhase = 0; nCentis = 0;
        end else if (e1) begin
          nMode = M_RUN;
        end
      end
    endcase
    if (reset) begin
      nMode = M_IDLE; nPhase = 0; nCentis = 0;
      nTick = 1'b0; nOvf = 1'b0;
    end
    mMode   <= nMode;
    mPhase  <= nPhase;
    mCentis <= nCentis;
    mTick   <= nTick;
    mOvf    <= nOvf;
    hVal    <= reset ? 3'b0 : {hVal[1:0], b1};
    hReal   <= reset ? 3'b0 : {hReal[1:0], 1'b1};
    gVal    <= reset ? 3'b0 : {gVal[1:0], b3};
    gReal   <= reset ? 3'b0 : {gReal[1:0], 1'b1};
  end

  function automatic logic [7:0] toBcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [26:0] expVec();
    int h, s, m;
    h = mCentis % 100;
    s = (mCentis / 100) % 60;
    m = mCentis / 6000;
    return {mMode == M_RUN, toBcd(m), toBcd(s), toBcd(h), mTick, mOvf};
  endfunction

  task automatic pulse(input bit p1, input bit p3);
    b1 = p1; b3 = p3;
    @(negedge mclk);
    b1 = 1'b0; b3 = 1'b0;
  endtask

  task preload(input int c);
    pMin = toBcd(c / 6000);
    pSec = toBcd((c / 100) % 60);
    pMil = toBcd(c % 100);
    force dut.uMin.val = pMin;
    force dut.uSec.val = pSec;
    force dut.uMil.val = pMil;
    preloadReq = c;
    @(negedge mclk);
    release dut.uMin.val;
    release dut.uSec.val;
    release dut.uMil.val;
    preloadReq = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    checks++;
    if ({run, min, sec, mil, tick, ovf} !== 27'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h want 0", {run, min, sec, mil, tick, ovf});
    end
    reset = 1'b0;
    repeat (3) @(negedge mclk);
    checks++;
    if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {run, min, sec, mil, tick, ovf}, expVec());
    end
  endtask

  task automatic test_start();
    pulse(1'b1, 1'b0);
    @(negedge mclk);
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL start_early: run %b want 0", run);
    end
    @(negedge mclk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: run %b want 1", run);
    end
    for (int i = 1; i <= 100; i++) begin
      @(negedge mclk);
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL start_model c%0d: got %h want %h", i, {run, min, sec, mil, tick, ovf}, expVec());
      end
      checks++;
      if (tick !== (i % 10 == 0) || mil !== toBcd(i / 10)) begin
        errors++;
        $display("FAIL start_tick c%0d: tick %b mil %h want %b %h", i, tick, mil, (i % 10 == 0), toBcd(i / 10));
      end
    end
    checks++;
    if (mil !== 8'h10) begin
      errors++;
      $display("FAIL bcd_carry: mil %h want 10", mil);
    end
  endtask

  task automatic test_pause_resume();
    int cnt;
    @(negedge mclk);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: run %b want 0", run);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge mclk);
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== {1'b0, 24'h000010, 2'b00} ||
          {run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL pause_frozen c%0d: got %h want %h", i, {run, min, sec, mil, tick, ovf}, expVec());
      end
    end
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL resume: run %b want 1", run);
    end
    cnt = 0;
    while (cnt < 20) begin
      @(negedge mclk);
      cnt++;
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL resume_model: got %h want %h", {run, min, sec, mil, tick, ovf}, expVec());
      end
      if (tick) break;
    end
    checks++;
    if (cnt !== 6 || mil !== 8'h11) begin
      errors++;
      $display("FAIL resume_partial: cycles %0d mil %h want 6 11", cnt, mil);
    end
  endtask

  task automatic test_clear_rules();
    int cnt;
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec() || run !== 1'b1) begin
        errors++;
        $display("FAIL clr_in_run c%0d: got %h want %h", i, {run, min, sec, mil, tick, ovf}, expVec());
      end
    end
    checks++;
    if (mil !== 8'h13) begin
      errors++;
      $display("FAIL clr_in_run_count: mil %h want 13", mil);
    end
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge mclk);
    checks++;
    if ({run, min, sec, mil} !== 25'h0 || {run, min, sec, mil, tick, ovf} !== expVec()) begin
      errors++;
      $display("FAIL clr_in_pause: got %h want 0", {run, min, sec, mil});
    end
    pulse(1'b1, 1'b1);
    repeat (2) @(negedge mclk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL both_in_idle: run %b want 1", run);
    end
    cnt = 0;
    while (cnt < 20) begin
      @(negedge mclk);
      cnt++;
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL idle_restart_model: got %h want %h", {run, min, sec, mil, tick, ovf}, expVec());
      end
      if (tick) break;
    end
    checks++;
    if (cnt !== 10 || mil !== 8'h01) begin
      errors++;
      $display("FAIL prescaler_cleared: cycles %0d mil %h want 10 01", cnt, mil);
    end
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    pulse(1'b1, 1'b1);
    repeat (2) @(negedge mclk);
    checks++;
    if ({run, min, sec, mil} !== 25'h0 || {run, min, sec, mil, tick, ovf} !== expVec()) begin
      errors++;
      $display("FAIL both_in_pause: got %h want 0", {run, min, sec, mil});
    end
  endtask

  task automatic test_cascade();
    int nt;
    bit done;
    nt = 0;
    done = 1'b0;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    for (int c = 0; c < 60100 && !done; c++) begin
      @(negedge mclk);
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL cascade_model: got %h want %h", {run, min, sec, mil, tick, ovf}, expVec());
      end
      checks++;
      if (min[7:4] > 9 || min[3:0] > 9 || sec[7:4] > 5 || sec[3:0] > 9 ||
          mil[7:4] > 9 || mil[3:0] > 9) begin
        errors++;
        $display("FAIL cascade_digits: got %h:%h.%h", min, sec, mil);
      end
      if (tick) begin
        nt++;
        if (nt == 5999) begin
          checks++;
          if ({min, sec, mil} !== 24'h005999) begin
            errors++;
            $display("FAIL cascade_pre: got %h want 005999", {min, sec, mil});
          end
        end
        if (nt == 6000) begin
          done = 1'b1;
          checks++;
          if ({min, sec, mil} !== 24'h010000) begin
            errors++;
            $display("FAIL cascade_min: got %h want 010000", {min, sec, mil});
          end
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL cascade_timeout: ticks %0d want 6000", nt);
    end
  endtask

  task automatic test_overflow();
    int cnt;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    preload(FULL - 1);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge mclk);
      cnt++;
      checks++;
      if ({run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL ovf_model: got %h want %h", {run, min, sec, mil, tick, ovf}, expVec());
      end
      if (tick) break;
    end
    checks++;
    if ({run, min, sec, mil, tick, ovf} !== {1'b1, 24'h000000, 2'b11}) begin
      errors++;
      $display("FAIL ovf_wrap: got %h want %h", {run, min, sec, mil, tick, ovf}, {1'b1, 24'h0, 2'b11});
    end
    @(negedge mclk);
    checks++;
    if (ovf !== 1'b0 || run !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pulse: ovf %b run %b want 0 1", ovf, run);
    end
  endtask

  task automatic test_mid_reset();
    int cnt;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    preload(1233);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    cnt = 0;
    while (cnt < 20 && !(tick === 1'b1)) begin
      @(negedge mclk);
      cnt++;
    end
    checks++;
    if ({run, min, sec, mil} !== {1'b1, 24'h001234}) begin
      errors++;
      $display("FAIL mid_reset_setup: got %h want 1001234", {run, min, sec, mil});
    end
    b1 = 1'b1;
    reset = 1'b1;
    @(negedge mclk);
    reset = 1'b0;
    checks++;
    if ({run, min, sec, mil, tick, ovf} !== 27'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h want 0", {run, min, sec, mil, tick, ovf});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge mclk);
      checks++;
      if (run !== 1'b0 || {run, min, sec, mil, tick, ovf} !== expVec()) begin
        errors++;
        $display("FAIL held_b1 c%0d: run %b want 0", i, run);
      end
    end
    b1 = 1'b0;
    repeat (3) @(negedge mclk);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge mclk);
    checks++;
    if (run !== 1'b1 || {run, min, sec, mil, tick, ovf} !== expVec()) begin
      errors++;
      $display("FAIL restart_after_reset: run %b want 1", run);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_clear_rules();
    test_cascade();
    test_overflow();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
